write_port_scheduler: RTL and testbench

//  Grant scheduler for the shared SRAM write path. Picks one of NUM_PORTS

---
 rtl/write_port_scheduler_pkg.sv | 31 +++
 rtl/write_port_scheduler_if.sv | 38 +++
 rtl/write_port_scheduler_rr_pick.sv | 31 +++
 rtl/write_port_scheduler.sv | 123 ++++++++++++
 tb/tb_write_port_scheduler.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/write_port_scheduler_pkg.sv
// Shared types and helpers for the SRAM write-port grant scheduler.
package write_port_scheduler_pkg;

    localparam int unsigned NUM_PORTS_DEF = 16;
    localparam int unsigned WEIGHT_W_DEF  = 4;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } sched_state_e;

    typedef enum logic [0:0] {
        MODE_SP  = 1'b0,
        MODE_WRR = 1'b1
    } sched_mode_e;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

    // A zero weight still earns one packet per visit.
    function automatic int unsigned eff_w(input int unsigned w);
        return (w == 0) ? 32'd1 : w;
    endfunction

endpackage

// File: rtl/write_port_scheduler_if.sv
// Request/grant bundle between the ingress ports and the write-port scheduler.
interface write_port_scheduler_if
    import write_port_scheduler_pkg::*;
#(
    parameter int unsigned NUM_PORTS = NUM_PORTS_DEF,
    parameter int unsigned WEIGHT_W  = WEIGHT_W_DEF,
    parameter int unsigned IDX_W     = clog2(NUM_PORTS)
);

    logic                          sp0_wrr1;
    logic [NUM_PORTS-1:0]          req;
    logic [NUM_PORTS*WEIGHT_W-1:0] weight_p;
    logic                          pkt_done;
    logic [NUM_PORTS-1:0]          grant;
    logic [IDX_W-1:0]              grant_idx;
    logic                          grant_valid;

    modport master (
        output sp0_wrr1,
        output req,
        output weight_p,
        output pkt_done,
        input  grant,
        input  grant_idx,
        input  grant_valid
    );

    modport slave (
        input  sp0_wrr1,
        input  req,
        input  weight_p,
        input  pkt_done,
        output grant,
        output grant_idx,
        output grant_valid
    );

endinterface

// File: rtl/write_port_scheduler_rr_pick.sv
// Combinational first-one finder starting at a rotating base index, wrapping modulo N.
module write_port_scheduler_rr_pick
    import write_port_scheduler_pkg::*;
#(
    parameter int unsigned N  = NUM_PORTS_DEF,
    parameter int unsigned IW = clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_base,
    output logic [N-1:0]  o_onehot,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    always_comb begin
        int unsigned pos;
        o_onehot = '0;
        o_idx    = '0;
        o_any    = 1'b0;
        pos      = 0;
        for (int unsigned i = 0; i < N; i++) begin
            pos = (32'(i_base) + i) % N;
            if (!o_any && i_req[pos]) begin
                o_any         = 1'b1;
                o_idx         = IW'(pos);
                o_onehot[pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/write_port_scheduler.sv
// Packet-granular SP/WRR grant scheduler for the shared SRAM write path.
module write_port_scheduler
    import write_port_scheduler_pkg::*;
#(
    parameter int unsigned NUM_PORTS = NUM_PORTS_DEF,
    parameter int unsigned WEIGHT_W  = WEIGHT_W_DEF,
    parameter int unsigned IDX_W     = clog2(NUM_PORTS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    write_port_scheduler_if.slave  sched_if
);

    localparam int unsigned CNT_W = WEIGHT_W + 1;

    sched_state_e         r_state, w_state_d;
    sched_mode_e          r_mode, w_mode_d;
    logic [IDX_W-1:0]     r_ptr, w_ptr_d;
    logic [CNT_W-1:0]     r_cnt, w_cnt_d;
    logic [NUM_PORTS-1:0] r_grant, w_grant_d;
    logic [IDX_W-1:0]     r_idx, w_idx_d;
    logic                 r_valid, w_valid_d;

    logic [IDX_W-1:0]     w_ptr_inc;
    logic [IDX_W-1:0]     w_base;
    logic [WEIGHT_W-1:0]  w_ptr_weight;
    logic                 w_keep;
    logic [NUM_PORTS-1:0] w_pick_oh;
    logic [IDX_W-1:0]     w_pick_idx;
    logic                 w_pick_any;
    logic [NUM_PORTS-1:0] w_ptr_oh;

    assign w_ptr_inc    = (r_ptr == IDX_W'(NUM_PORTS - 1)) ? '0 : r_ptr + IDX_W'(1);
    assign w_base       = sched_if.sp0_wrr1 ? w_ptr_inc : '0;
    assign w_ptr_weight = sched_if.weight_p[32'(r_ptr) * WEIGHT_W +: WEIGHT_W];
    assign w_ptr_oh     = {{(NUM_PORTS - 1){1'b0}}, 1'b1} << r_ptr;
    // Current port keeps the slot while it still requests and has budget left.
    assign w_keep       = sched_if.req[r_ptr] && (32'(r_cnt) < eff_w(32'(w_ptr_weight)));

    write_port_scheduler_rr_pick #(
        .N  (NUM_PORTS),
        .IW (IDX_W)
    ) u_rr_pick (
        .i_req    (sched_if.req),
        .i_base   (w_base),
        .o_onehot (w_pick_oh),
        .o_idx    (w_pick_idx),
        .o_any    (w_pick_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            ST_IDLE: if (w_pick_any)        w_state_d = ST_BUSY;
            ST_BUSY: if (sched_if.pkt_done) w_state_d = ST_IDLE;
            default:                        w_state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        w_mode_d  = r_mode;
        w_ptr_d   = r_ptr;
        w_cnt_d   = r_cnt;
        w_grant_d = r_grant;
        w_idx_d   = r_idx;
        w_valid_d = r_valid;
        if (r_state == ST_IDLE) begin
            if (w_pick_any) begin
                w_valid_d = 1'b1;
                w_mode_d  = sched_if.sp0_wrr1 ? MODE_WRR : MODE_SP;
                if (sched_if.sp0_wrr1 && w_keep) begin
                    w_grant_d = w_ptr_oh;
                    w_idx_d   = r_ptr;
                end else begin
                    w_grant_d = w_pick_oh;
                    w_idx_d   = w_pick_idx;
                    if (sched_if.sp0_wrr1) begin
                        w_ptr_d = w_pick_idx;
                        w_cnt_d = '0;
                    end
                end
            end
        end else if (sched_if.pkt_done) begin
            w_grant_d = '0;
            w_idx_d   = '0;
            w_valid_d = 1'b0;
            if (r_mode == MODE_WRR) begin
                w_cnt_d = r_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode  <= MODE_SP;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_grant <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_mode  <= w_mode_d;
            r_ptr   <= w_ptr_d;
            r_cnt   <= w_cnt_d;
            r_grant <= w_grant_d;
            r_idx   <= w_idx_d;
            r_valid <= w_valid_d;
        end
    end

    assign sched_if.grant       = r_grant;
    assign sched_if.grant_idx   = r_idx;
    assign sched_if.grant_valid = r_valid;

endmodule

// File: tb/tb_write_port_scheduler.sv
// Directed bench for write_port_scheduler: SP, WRR, weight-zero, wrap, reset and freeze cases.
module tb_write_port_scheduler;

    localparam int unsigned NP = 16;
    localparam int unsigned WW = 4;
    localparam int unsigned IW = 4;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    write_port_scheduler_if #(.NUM_PORTS(NP), .WEIGHT_W(WW), .IDX_W(IW)) bus_if ();

    write_port_scheduler #(
        .NUM_PORTS (NP),
        .WEIGHT_W  (WW),
        .IDX_W     (IW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sched_if (bus_if.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_grant(input string tag, input int idx);
        check({tag, "_grant"}, 32'(bus_if.grant), 32'd1 << idx);
        check({tag, "_idx"}, 32'(bus_if.grant_idx), 32'(idx));
        check({tag, "_valid"}, 32'(bus_if.grant_valid), 32'd1);
    endtask

    task automatic expect_idle(input string tag);
        check({tag, "_grant"}, 32'(bus_if.grant), 32'd0);
        check({tag, "_valid"}, 32'(bus_if.grant_valid), 32'd0);
    endtask

    // Decision edge, check grant, then a pkt_done pulse and check the bubble.
    task automatic run_pkt(input string tag, input int idx);
        cyc();
        expect_grant(tag, idx);
        bus_if.pkt_done = 1'b1;
        cyc();
        bus_if.pkt_done = 1'b0;
        expect_idle({tag, "_bubble"});
    endtask

    int seq3 [8] = '{1, 1, 1, 5, 1, 1, 1, 5};
    int seq5 [4] = '{0, 15, 0, 15};

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus_if.sp0_wrr1 = 1'b0;
        bus_if.req      = '0;
        bus_if.weight_p = '0;
        bus_if.pkt_done = 1'b0;
        cyc();
        cyc();
        expect_idle("reset");
        check("reset_idx", 32'(bus_if.grant_idx), 32'd0);
        rst_n = 1'b1;
        cyc();
        expect_idle("post_reset");

        // Strict priority: lowest requesting index wins, re-granted after bubble.
        bus_if.req = 16'h0014;
        run_pkt("sp_a", 2);
        run_pkt("sp_b", 2);

        // BUSY ignores req and mode changes.
        cyc();
        expect_grant("busy0", 2);
        bus_if.req      = 16'h0001;
        bus_if.sp0_wrr1 = 1'b1;
        cyc();
        cyc();
        expect_grant("frozen", 2);
        bus_if.pkt_done = 1'b1;
        bus_if.req      = '0;
        bus_if.sp0_wrr1 = 1'b0;
        cyc();
        bus_if.pkt_done = 1'b0;
        expect_idle("release");
        bus_if.pkt_done = 1'b1;
        cyc();
        bus_if.pkt_done = 1'b0;
        cyc();
        expect_idle("done_in_idle");

        // Asynchronous reset in the middle of a grant.
        bus_if.req = 16'h0014;
        cyc();
        expect_grant("pre_rst", 2);
        #2 rst_n = 1'b0;
        #1;
        expect_idle("async_rst");
        check("async_rst_idx", 32'(bus_if.grant_idx), 32'd0);
        bus_if.req = '0;
        cyc();
        rst_n = 1'b1;
        cyc();
        expect_idle("rst_release");

        // WRR: port1 weight 3, port5 weight 1, from ptr=0 cnt=0.
        bus_if.sp0_wrr1       = 1'b1;
        bus_if.weight_p       = '0;
        bus_if.weight_p[7:4]  = 4'd3;
        bus_if.weight_p[23:20] = 4'd1;
        bus_if.req            = 16'h0022;
        for (int i = 0; i < 8; i++) begin
            run_pkt($sformatf("wrr_%0d", i), seq3[i]);
        end
        bus_if.req = '0;

        // WRR: zero weight on a lone requester behaves as weight 1.
        bus_if.weight_p = '0;
        bus_if.req      = 16'h0008;
        for (int i = 0; i < 3; i++) begin
            run_pkt($sformatf("w0_%0d", i), 3);
        end
        bus_if.req = '0;

        // WRR wrap between port 15 and port 0.
        bus_if.weight_p        = '0;
        bus_if.weight_p[63:60] = 4'd1;
        bus_if.weight_p[3:0]   = 4'd1;
        bus_if.req             = 16'h8000;
        run_pkt("wrap_pre", 15);
        bus_if.req = 16'h8001;
        for (int i = 0; i < 4; i++) begin
            run_pkt($sformatf("wrap_%0d", i), seq5[i]);
        end
        bus_if.req = '0;
        cyc();
        expect_idle("end");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
